wide_bus_collector: RTL and testbench

//  Consumer end of the hierarchy's wide producer buses (leaf/mid blocks drive 15..900-bit vectors).

---
 rtl/wbc_pkg.sv | 18 +
 rtl/wbc_beat_counter.sv | 26 ++
 rtl/wide_bus_collector.sv | 93 +++++++++
 tb/tb_wide_bus_collector.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/wbc_pkg.sv
// Shared types and sizing helpers for the wide bus collector.
package wbc_pkg;

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_t;

  function automatic int nbeats(input int bus_w, input int beat_w);
    return (bus_w + beat_w - 1) / beat_w;
  endfunction

  // Width of the beat counter; never zero, even for single-beat frames.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int DEF_NBEATS = nbeats(900, 30);
  localparam int DEF_CNT_W  = cnt_w(DEF_NBEATS);

endpackage

// File: rtl/wbc_beat_counter.sv
// Beat index within the frame being collected; wraps to zero after the final beat.
module wbc_beat_counter
  import wbc_pkg::*;
#(
  parameter int NBEATS = DEF_NBEATS,
  localparam int CNT_W = cnt_w(NBEATS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clear,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  assign at_max = (count == CNT_W'(NBEATS - 1));

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (inc) begin
      count <= at_max ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/wide_bus_collector.sv
// Reassembles a BUS_W-bit vector from BEAT_W-bit beats and holds it for a downstream handshake.
// Optional beat parity checking is built when WBC_PARITY_EN is defined.
module wide_bus_collector
  import wbc_pkg::*;
#(
  parameter int BUS_W  = 900,
  parameter int BEAT_W = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [BEAT_W-1:0] in_data,
  input  logic              in_last,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BUS_W-1:0]  out_data,
  output logic              out_short,
  output logic              par_err
);

  localparam int NBEATS = nbeats(BUS_W, BEAT_W);
  localparam int CNT_W  = cnt_w(NBEATS);
  localparam logic [BUS_W-1:0] LANE = BUS_W'({BEAT_W{1'b1}});

  state_t           state, state_next;
  logic [CNT_W-1:0] count;
  logic             at_max;
  logic             accept, close, drain;
  logic [31:0]      ofs;
  logic [BUS_W-1:0] beat_mask, beat_bits;

  assign in_ready  = (state != HOLD) && !reset;
  assign out_valid = (state == HOLD);
  assign accept    = in_valid && in_ready;
  assign close     = accept && (in_last || at_max);
  assign drain     = (state == HOLD) && out_ready;

  wbc_beat_counter #(.NBEATS(NBEATS)) u_count (
    .clk    (clk),
    .reset  (reset),
    .inc    (accept && !close),
    .clear  (close),
    .count  (count),
    .at_max (at_max)
  );

  // Slice decoder: bits shifted past BUS_W-1 fall off, trimming a ragged final beat.
  assign ofs       = 32'(count) * 32'(BEAT_W);
  assign beat_mask = LANE << ofs;
  assign beat_bits = BUS_W'(in_data) << ofs;

  always_ff @(posedge clk) begin
    if (reset || drain) begin
      out_data  <= '0;
      out_short <= 1'b0;
    end else if (accept) begin
      out_data <= (out_data & ~beat_mask) | beat_bits;
      if (close) out_short <= in_last && !at_max;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = close ? HOLD : FILL;
      FILL:    if (close) state_next = HOLD;
      HOLD:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

`ifdef WBC_PARITY_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      par_err <= 1'b0;
    end else if (accept && ((^in_data) ^ in_par)) begin
      par_err <= 1'b1;
    end
  end
`else
  logic par_unused;
  assign par_unused = in_par;
  assign par_err    = 1'b0;
`endif

endmodule

// File: tb/tb_wide_bus_collector.sv
// Table-driven, hand-sequenced and randomized checks of wide_bus_collector against a frame model.
module tb_wide_bus_collector;

  localparam int BUS_W  = 900;
  localparam int BEAT_W = 30;
  localparam int NB     = 30;
`ifdef WBC_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif

  logic              clk, reset;
  logic              in_valid, in_ready, in_last, in_par;
  logic [BEAT_W-1:0] in_data;
  logic              out_valid, out_ready, out_short, par_err;
  logic [BUS_W-1:0]  out_data;

  int vectors = 0;
  int miscompares = 0;
  bit par_model = 1'b0;
  logic [BEAT_W-1:0] beat_q [NB];

  typedef struct {
    int          n;
    bit          use_last;
    logic [29:0] base;
    logic [29:0] step;
    int          gap;
    int          hold;
    bit          exp_short;
  } vec_t;

  vec_t tbl [6];

  wide_bus_collector #(.BUS_W(BUS_W), .BEAT_W(BEAT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_par    (in_par),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_short (out_short),
    .par_err   (par_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [BUS_W-1:0] act, input logic [BUS_W-1:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [BEAT_W-1:0] d, input bit last, input bit bad);
    int waited = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    in_par   = (^d) ^ bad;
    while (!in_ready && waited < 50) begin
      tick();
      waited++;
    end
    if (!in_ready) chk("in_ready_timeout", 0, 1);
    tick();
    if (bad && PAR_EN) par_model = 1'b1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Sends beat_q[0..n-1] and checks the reassembled frame through backpressure and drain.
  task automatic run_frame(input int n, input bit use_last, input int gap, input int hold,
                           input bit exp_short, input int bad_idx);
    logic [BUS_W-1:0] exp = '0;
    for (int k = 0; k < n; k++) exp[k*BEAT_W +: BEAT_W] = beat_q[k];
    for (int k = 0; k < n; k++) begin
      send_beat(beat_q[k], use_last && (k == n - 1), k == bad_idx);
      if (k == bad_idx) chk("par_err_next", 900'(par_err), 900'(par_model));
      if (k == n - 2) chk("valid_midframe", 900'(out_valid), 0);
      if (k < n - 1) for (int g = 0; g < gap; g++) tick();
    end
    chk("valid_latency", 900'(out_valid), 1);
    chk("hold_ready", 900'(in_ready), 0);
    chk("frame_data", out_data, exp);
    chk("frame_short", 900'(out_short), 900'(exp_short));
    for (int h = 0; h < hold; h++) begin
      in_valid = 1'b1;
      in_last  = 1'b1;
      in_data  = BEAT_W'($urandom);
      tick();
      chk("bp_ready", 900'(in_ready), 0);
      chk("bp_data", out_data, exp);
      chk("bp_short", 900'(out_short), 900'(exp_short));
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("drain_valid", 900'(out_valid), 0);
    chk("drain_data", out_data, 0);
    chk("drain_ready", 900'(in_ready), 1);
    chk("par_err_frame", 900'(par_err), 900'(par_model));
  endtask

  initial begin
    in_valid = 0; in_data = '0; in_last = 0; in_par = 0; out_ready = 0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_ready", 900'(in_ready), 0);
    chk("rst_valid", 900'(out_valid), 0);
    chk("rst_data", out_data, 0);
    chk("rst_short", 900'(out_short), 0);
    chk("rst_par", 900'(par_err), 0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", 900'(in_ready), 1);

    tbl[0] = '{30, 1'b0, 30'h0,        30'h1, 0, 0, 1'b0};
    tbl[1] = '{30, 1'b1, 30'h100,      30'h3, 0, 5, 1'b0};
    tbl[2] = '{4,  1'b1, 30'hA,        30'h1, 0, 0, 1'b1};
    tbl[3] = '{1,  1'b1, 30'h3FFFFFFF, 30'h0, 0, 2, 1'b1};
    tbl[4] = '{30, 1'b0, 30'h0,        30'h1, 1, 1, 1'b0};
    tbl[5] = '{29, 1'b1, 30'h5,        30'h7, 0, 0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      for (int k = 0; k < NB; k++) beat_q[k] = tbl[i].base + 30'(k) * tbl[i].step;
      run_frame(tbl[i].n, tbl[i].use_last, tbl[i].gap, tbl[i].hold, tbl[i].exp_short, -1);
    end

    // Reset in the middle of a frame, then a full frame of all-ones beats.
    for (int k = 0; k < 10; k++) send_beat(BEAT_W'(k + 77), 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    chk("midrst_ready", 900'(in_ready), 0);
    tick();
    reset = 1'b0;
    par_model = 1'b0;
    #1;
    chk("midrst_data", out_data, 0);
    chk("midrst_valid", 900'(out_valid), 0);
    for (int k = 0; k < NB; k++) beat_q[k] = 30'h3FFFFFFF;
    run_frame(30, 1'b0, 0, 0, 1'b0, -1);

    // Bad parity on beat 7, then a clean frame, then reset.
    for (int k = 0; k < NB; k++) beat_q[k] = BEAT_W'($urandom);
    run_frame(30, 1'b1, 0, 0, 1'b0, 7);
    for (int k = 0; k < NB; k++) beat_q[k] = BEAT_W'($urandom);
    run_frame(12, 1'b1, 0, 1, 1'b1, -1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    par_model = 1'b0;
    #1;
    chk("par_after_rst", 900'(par_err), 0);

    // Random frames: length, early last, gaps, backpressure and payload all drawn at random.
    for (int r = 0; r < 20; r++) begin
      int n;
      bit ul;
      n  = int'($urandom_range(1, NB));
      ul = (n < NB) ? 1'b1 : 1'($urandom_range(0, 1));
      for (int k = 0; k < NB; k++) beat_q[k] = BEAT_W'($urandom);
      run_frame(n, ul, int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                ul && (n < NB), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
